// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for a single-cycle, word-addressed,
// full-word-write data memory. Takes one load/store at a time over a
// valid/ready handshake, extracts and extends sub-word load data, and performs
// SB/SH as read-modify-write.
// Optional feature macro: LSU_ERR_EN (enables misalignment, out-of-range and
// illegal-funct3 detection; when undefined, resp_err is tied low).
module load_store_unit #(
  parameter int Width     = 32,
  parameter int MEM_DEPTH = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [2:0]         req_funct3,
  input  logic [Width-1:0]   req_addr,
  input  logic [Width-1:0]   req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [Width-1:0]   resp_rdata,
  output logic               resp_err,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [Width-1:0]   address,
  output logic [Width-1:0]   WriteData,
  input  logic [2*Width-1:0] ReadData
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  state_t             state, state_next;
  logic               write_q;
  logic [2:0]         funct3_q;
  logic [1:0]         lane_q;
  logic [Width-1:0]   wdata_q;

  logic               accept;
  logic [Width-1:0]   word_idx;
  logic               in_range;
  logic               req_err;
  logic [2:0]         funct3_eff;
  logic [Width-1:0]   rd_word;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [Width-1:0]   load_data;
  logic [Width-1:0]   merge_data;
  logic               unused_sink;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr >> 2;
  assign in_range  = word_idx < Width'(MEM_DEPTH);
  assign rd_word   = ReadData[Width-1:0];

`ifdef LSU_ERR_EN
  assign unused_sink = ^ReadData[2*Width-1:Width];
`else
  assign unused_sink = ^{ReadData[2*Width-1:Width], in_range};
`endif

  // Classify the incoming request: error flag and the funct3 actually executed.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    req_err    = 1'b0;
    funct3_eff = req_funct3;
`ifdef LSU_ERR_EN
    if (req_write) begin
      if (req_funct3 > 3'b010) req_err = 1'b1;
    end else if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
      req_err = 1'b1;
    end
    case (req_funct3[1:0])
      2'b01:   if (req_addr[0]) req_err = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: ;
    endcase
    if (!in_range) req_err = 1'b1;
`else
    // Without error checking, unknown encodings fall back to a full word access.
    if (req_write ? (req_funct3 > 3'b010)
                  : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111))
      funct3_eff = 3'b010;
`endif
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_sel   = rd_word[{lane_q, 3'b000} +: 8];
    half_sel   = rd_word[{lane_q[1], 4'b0000} +: 16];
    load_data  = rd_word;
    merge_data = rd_word;
    case (funct3_q)
      3'b000:  load_data = {{(Width-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(Width-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(Width-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(Width-16){1'b0}}, half_sel};
      default: load_data = rd_word;
    endcase
    case (funct3_q[1:0])
      2'b00:   merge_data[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_data = wdata_q;
    endcase
  end

  // Next-state logic: sub-word stores and all loads read first, SW writes directly.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                                state_next = RESP;
        else if (!req_write || funct3_eff != 3'b010) state_next = READ;
        else                                        state_next = WRITE;
      end
      READ:    state_next = MERGE;
      MERGE:   state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, request capture and registered memory/response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      address    <= '0;
      WriteData  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      MemRead    <= (state_next == READ);
      MemWrite   <= (state_next == WRITE);
      resp_valid <= (state_next == RESP);
      if (accept) begin
        write_q    <= req_write;
        funct3_q   <= funct3_eff;
        lane_q     <= req_addr[1:0];
        wdata_q    <= req_wdata;
        address    <= word_idx;
        WriteData  <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= req_err;
      end
      if (state == MERGE) begin
        if (write_q) WriteData  <= merge_data;
        else         resp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed requests against a bench-side data
// memory, with a byte-level reference model predicting every response.
module tb_load_store_unit;

`ifdef LSU_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] WriteData;
  logic [63:0] ReadData;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .address    (address),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [512];   // memory the DUT talks to
  logic [31:0] ref_mem [512];   // model's view of the same memory

  // Expectations for the cycle-by-cycle monitor.
  logic [31:0] exp_idx, exp_wdata, exp_rdata, last_wdata;
  logic        exp_err;
  int          rd_cnt, wr_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req_v);
    end
  endtask

  // Single-cycle memory: read data appears the cycle after MemRead; upper half is junk.
  always @(posedge clk) begin
    if (MemWrite) mem[address[8:0]] <= WriteData;
    if (MemRead)  ReadData <= {32'hA5A5_5A5A, mem[address[8:0]]};
  end

  // Monitor: checks strobes and responses against the current expectation.
  always @(negedge clk) begin
    if (MemRead || MemWrite) check("strobe_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
    if (MemRead) begin
      rd_cnt++;
      check("read_addr", address, exp_idx);
    end
    if (MemWrite) begin
      wr_cnt++;
      last_wdata = WriteData;
      check("write_addr", address, exp_idx);
      check("write_data", WriteData, exp_wdata);
    end
    if (resp_valid) begin
      check("resp_rdata", resp_rdata, exp_rdata);
      check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    end
  end

  // Reference model: byte-lane arithmetic on the model memory.
  function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd,
                                output int lat, output int n_rd, output int n_wr);
    int          idx, off;
    logic [31:0] w, b, h, nw;
    logic [2:0]  f;
    bit          illegal;
    idx = int'(a >> 2);
    off = int'(a % 4);
    w   = ref_mem[idx % 512];
    f   = f3;
    illegal = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    err = 1'b0;
    if (ERR_EN)
      err = illegal || idx >= 512 || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && off != 0);
    else if (illegal)
      f = 3'd2;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    rd = 32'd0; n_rd = 0; n_wr = 0;
    if (err) begin
      lat = 1;
    end else if (!wr) begin
      lat = 3; n_rd = 1;
      case (f)
        3'd0:    rd = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        3'd1:    rd = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
        3'd4:    rd = b;
        3'd5:    rd = h;
        default: rd = w;
      endcase
    end else begin
      n_wr = 1;
      case (f)
        3'd0:    nw = (w & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
        3'd1:    nw = (w & ~(32'hFFFF << (16 * (off / 2)))) | ((wd & 32'hFFFF) << (16 * (off / 2)));
        default: nw = wd;
      endcase
      lat  = (f == 3'd2) ? 2 : 4;
      n_rd = (f == 3'd2) ? 0 : 1;
      exp_wdata = nw;
      ref_mem[idx % 512] = nw;
    end
  endfunction

  // One complete transaction; hold>0 stalls the response with a waiting request behind it.
  task automatic run_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit has_lit, input logic [31:0] lit,
                         input int hold);
    bit          e;
    logic [31:0] r;
    int          lat, nr, nw, cyc;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    model(wr, f3, a, wd, e, r, lat, nr, nw);
    exp_err = e; exp_rdata = r; exp_idx = a >> 2;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk);
    rd_cnt = 0; wr_cnt = 0;
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 20);
    check("latency", cyc, lat);
    check("read_strobes", rd_cnt, nr);
    check("write_strobes", wr_cnt, nw);
    if (has_lit) check("rdata_literal", resp_rdata, lit);
    if (hold > 0) begin
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1C;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_valid", {31'd0, resp_valid}, 32'd1);
        check("hold_rdata", resp_rdata, r);
        check("hold_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("resp_drop", {31'd0, resp_valid}, 32'd0);
    if (hold > 0) begin
      check("stray_not_taken", {31'd0, req_ready}, 32'd1);
      check("stray_no_strobe", rd_cnt + wr_cnt, nr + nw);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b1; ReadData = 64'd0;
    exp_idx = 32'd0; exp_wdata = 32'd0; exp_rdata = 32'd0; exp_err = 1'b0; last_wdata = 32'd0;
    rd_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = i;
      ref_mem[i] = i;
    end

    #12;
    check("rst_memread", {31'd0, MemRead}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_writedata", WriteData, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    run_req(1'b0, 3'b010, 32'h14, 32'd0, 1'b1, 32'h0000_0005, 0);    // LW
    run_req(1'b1, 3'b010, 32'h08, 32'h8081_F0FF, 1'b1, 32'd0, 0);    // SW
    check("sw_writedata", last_wdata, 32'h8081_F0FF);
    run_req(1'b0, 3'b000, 32'h08, 32'd0, 1'b1, 32'hFFFF_FFFF, 0);    // LB
    run_req(1'b0, 3'b100, 32'h09, 32'd0, 1'b1, 32'h0000_00F0, 0);    // LBU
    run_req(1'b0, 3'b001, 32'h0A, 32'd0, 1'b1, 32'hFFFF_8081, 0);    // LH
    run_req(1'b0, 3'b101, 32'h0A, 32'd0, 1'b1, 32'h0000_8081, 0);    // LHU
    run_req(1'b1, 3'b000, 32'h0D, 32'h1234_56AB, 1'b1, 32'd0, 0);    // SB (RMW)
    check("sb_writedata", last_wdata, 32'h0000_AB03);
    run_req(1'b0, 3'b010, 32'h0C, 32'd0, 1'b1, 32'h0000_AB03, 0);    // LW after SB

    // Misaligned, out-of-range and illegal encodings; outcome depends on LSU_ERR_EN.
    run_req(1'b0, 3'b010, 32'h06, 32'd0, 1'b0, 32'd0, 0);
    run_req(1'b0, 3'b010, 32'h800, 32'd0, 1'b0, 32'd0, 0);
    run_req(1'b0, 3'b011, 32'h10, 32'd0, 1'b0, 32'd0, 0);
    run_req(1'b1, 3'b111, 32'h20, 32'hCAFE_F00D, 1'b0, 32'd0, 0);
    run_req(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, 32'd0, 0);
    run_req(1'b0, 3'b001, 32'h0B, 32'd0, 1'b0, 32'd0, 0);

    run_req(1'b1, 3'b001, 32'h1E, 32'h0000_BEEF, 1'b1, 32'd0, 0);    // SH upper half
    run_req(1'b0, 3'b001, 32'h1E, 32'd0, 1'b1, 32'hFFFF_BEEF, 0);
    run_req(1'b1, 3'b000, 32'h13, 32'h0000_0077, 1'b1, 32'd0, 0);    // SB top byte
    run_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b1, 32'h7700_0004, 5);    // stalled response
    run_req(1'b0, 3'b010, 32'h1C, 32'd0, 1'b1, 32'hBEEF_0007, 0);

    // Reset during the MERGE cycle of an SH: the write must never happen.
    exp_idx = 32'd1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h4; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    rd_cnt = 0; wr_cnt = 0;
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_memread", {31'd0, MemRead}, 32'd0);
    check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
    check("abort_address", address, 32'd0);
    check("abort_writedata", WriteData, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_read_done", rd_cnt, 1);
    check("abort_no_write", wr_cnt, 0);
    check("abort_mem_word1", mem[1], 32'h0000_0001);
    @(posedge clk); #1 reset = 1'b0;
    run_req(1'b0, 3'b010, 32'h04, 32'd0, 1'b1, 32'h0000_0001, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
